// File: rtl/ex_mem_stage.sv
// Execute stage and EX/MEM pipeline register with a multi-cycle shift-add multiplier (HI/LO).
// Optional signed multiply (funct 0x18) is built when MULT_SIGNED_EN is defined.
module ex_mem_stage #(
    parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  WB_ctl_in,
    input  logic [3:0]  MEM_ctl_in,
    input  logic [1:0]  ALUop,
    input  logic        ALUsrc,
    input  logic        RegDst,
    input  logic [31:0] pc_in,
    input  logic [31:0] RD1_in,
    input  logic [31:0] RD2_in,
    input  logic [31:0] immed_exted_in,
    input  logic [4:0]  Rt_in,
    input  logic [4:0]  Rd_in,
    input  logic [4:0]  shamt_in,
    output logic [1:0]  WB_ctl_out,
    output logic [3:0]  MEM_ctl_out,
    output logic [31:0] branch_target_out,
    output logic        zero_out,
    output logic [31:0] ALU_result_out,
    output logic [31:0] RD2_out,
    output logic [4:0]  WN_out,
    output logic        stall_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned MUL_STEPS = 32 / MUL_BITS_PER_CYCLE;
    localparam logic [5:0]  LAST_STEP = 6'(MUL_STEPS - 1);

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;
`ifdef MULT_SIGNED_EN
    localparam logic [5:0] F_MULT  = 6'h18;
`endif

    state_t      state_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic [63:0] mcand_r;
    logic [63:0] acc_r;
    logic [31:0] mplier_r;
    logic [5:0]  step_r;
`ifdef MULT_SIGNED_EN
    logic        neg_r;
    logic        mul_signed_s;
`endif

    logic [5:0]  funct_s;
    logic [31:0] alu_b_s;
    logic [31:0] result_s;
    logic        valid_s;
    logic        mul_req_s;
    logic        stall_s;
    logic        load_s;
    logic [31:0] op_a_s;
    logic [31:0] op_b_s;
    logic [63:0] step_acc_s;
    logic [63:0] product_s;
    logic [31:0] branch_s;
    logic [4:0]  wn_s;

    // ALU control decode and ALU operation; multiply requests and unknown functs are not valid results
    always_comb begin
        funct_s   = immed_exted_in[5:0];
        alu_b_s   = ALUsrc ? immed_exted_in : RD2_in;
        result_s  = 32'd0;
        valid_s   = 1'b1;
        mul_req_s = 1'b0;
`ifdef MULT_SIGNED_EN
        mul_signed_s = 1'b0;
`endif
        case (ALUop)
            2'b00: result_s = RD1_in + alu_b_s;
            2'b01: result_s = RD1_in - alu_b_s;
            2'b11: result_s = RD1_in | alu_b_s;
            2'b10: begin
                case (funct_s)
                    F_ADD:  result_s = RD1_in + alu_b_s;
                    F_SUB:  result_s = RD1_in - alu_b_s;
                    F_AND:  result_s = RD1_in & alu_b_s;
                    F_OR:   result_s = RD1_in | alu_b_s;
                    F_SLT:  result_s = {31'd0, ($signed(RD1_in) < $signed(alu_b_s))};
                    F_SLL:  result_s = RD2_in << shamt_in;
                    F_SRL:  result_s = RD2_in >> shamt_in;
                    F_MFHI: result_s = hi_r;
                    F_MFLO: result_s = lo_r;
                    F_MULTU: begin
                        valid_s   = 1'b0;
                        mul_req_s = 1'b1;
                    end
`ifdef MULT_SIGNED_EN
                    F_MULT: begin
                        valid_s      = 1'b0;
                        mul_req_s    = 1'b1;
                        mul_signed_s = 1'b1;
                    end
`endif
                    default: valid_s = 1'b0;
                endcase
            end
            default: valid_s = 1'b0;
        endcase
    end

    // Branch target and destination register select
    always_comb begin
        branch_s = pc_in + {immed_exted_in[29:0], 2'b00};
        wn_s     = RegDst ? Rd_in : Rt_in;
    end

    // Multiplier operands: signed multiply works on magnitudes, sign restored at the end
    always_comb begin
`ifdef MULT_SIGNED_EN
        if (mul_signed_s) begin
            op_a_s = RD1_in[31] ? (32'd0 - RD1_in) : RD1_in;
            op_b_s = RD2_in[31] ? (32'd0 - RD2_in) : RD2_in;
        end else begin
            op_a_s = RD1_in;
            op_b_s = RD2_in;
        end
`else
        op_a_s = RD1_in;
        op_b_s = RD2_in;
`endif
    end

    // One shift-add step retiring MUL_BITS_PER_CYCLE multiplier bits
    always_comb begin
        step_acc_s = acc_r;
        for (int i = 0; i < int'(MUL_BITS_PER_CYCLE); i++) begin
            if (mplier_r[i]) begin
                step_acc_s = step_acc_s + (mcand_r << i);
            end else begin
                step_acc_s = step_acc_s;
            end
        end
`ifdef MULT_SIGNED_EN
        if (neg_r) begin
            product_s = 64'd0 - step_acc_s;
        end else begin
            product_s = step_acc_s;
        end
`else
        product_s = step_acc_s;
`endif
    end

    assign stall_s   = !rst && ((state_r == ST_BUSY) || ((state_r == ST_IDLE) && mul_req_s));
    assign stall_out = stall_s;
    assign load_s    = valid_s && (state_r != ST_BUSY);

    // Multiplier FSM with HI/LO; a held multiply in DONE is not restarted
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            mcand_r  <= 64'd0;
            acc_r    <= 64'd0;
            mplier_r <= 32'd0;
            step_r   <= 6'd0;
`ifdef MULT_SIGNED_EN
            neg_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (mul_req_s) begin
                        mcand_r  <= {32'd0, op_a_s};
                        mplier_r <= op_b_s;
                        acc_r    <= 64'd0;
                        step_r   <= 6'd0;
`ifdef MULT_SIGNED_EN
                        neg_r    <= mul_signed_s && (RD1_in[31] ^ RD2_in[31]);
`endif
                        state_r  <= ST_BUSY;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc_r    <= step_acc_s;
                    mcand_r  <= mcand_r << MUL_BITS_PER_CYCLE;
                    mplier_r <= mplier_r >> MUL_BITS_PER_CYCLE;
                    step_r   <= step_r + 6'd1;
                    if (step_r == LAST_STEP) begin
                        hi_r    <= product_s[63:32];
                        lo_r    <= product_s[31:0];
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // EX/MEM pipeline register; bubbles clear every field
    always_ff @(posedge clk) begin
        if (rst || !load_s) begin
            WB_ctl_out        <= 2'd0;
            MEM_ctl_out       <= 4'd0;
            branch_target_out <= 32'd0;
            zero_out          <= 1'b0;
            ALU_result_out    <= 32'd0;
            RD2_out           <= 32'd0;
            WN_out            <= 5'd0;
        end else begin
            WB_ctl_out        <= WB_ctl_in;
            MEM_ctl_out       <= MEM_ctl_in;
            branch_target_out <= branch_s;
            zero_out          <= (result_s == 32'd0);
            ALU_result_out    <= result_s;
            RD2_out           <= RD2_in;
            WN_out            <= wn_s;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: vector table for single-cycle ops, hand sequences for multiply and reset.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  WB_ctl_in;
    logic [3:0]  MEM_ctl_in;
    logic [1:0]  ALUop;
    logic        ALUsrc;
    logic        RegDst;
    logic [31:0] pc_in;
    logic [31:0] RD1_in;
    logic [31:0] RD2_in;
    logic [31:0] immed_exted_in;
    logic [4:0]  Rt_in;
    logic [4:0]  Rd_in;
    logic [4:0]  shamt_in;
    logic [1:0]  WB_ctl_out;
    logic [3:0]  MEM_ctl_out;
    logic [31:0] branch_target_out;
    logic        zero_out;
    logic [31:0] ALU_result_out;
    logic [31:0] RD2_out;
    logic [4:0]  WN_out;
    logic        stall_out;

    ex_mem_stage #(.MUL_BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst),
        .WB_ctl_in(WB_ctl_in), .MEM_ctl_in(MEM_ctl_in),
        .ALUop(ALUop), .ALUsrc(ALUsrc), .RegDst(RegDst),
        .pc_in(pc_in), .RD1_in(RD1_in), .RD2_in(RD2_in),
        .immed_exted_in(immed_exted_in), .Rt_in(Rt_in), .Rd_in(Rd_in), .shamt_in(shamt_in),
        .WB_ctl_out(WB_ctl_out), .MEM_ctl_out(MEM_ctl_out),
        .branch_target_out(branch_target_out), .zero_out(zero_out),
        .ALU_result_out(ALU_result_out), .RD2_out(RD2_out), .WN_out(WN_out),
        .stall_out(stall_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  aluop;
        logic        alusrc;
        logic        regdst;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [1:0]  wb;
        logic [3:0]  mem;
        logic        e_bubble;
        logic [31:0] e_res;
        logic        e_zero;
        logic [4:0]  e_wn;
        logic [31:0] e_bt;
    } vec_t;

    vec_t vecs[13];
    int n_vec = 0;
    int n_bad = 0;

    function automatic vec_t mk(input string name, input logic [1:0] aluop, input logic alusrc,
                                input logic regdst, input logic [31:0] pc, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic [31:0] imm, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] shamt, input logic [1:0] wb,
                                input logic [3:0] mem, input logic e_bubble, input logic [31:0] e_res,
                                input logic e_zero, input logic [4:0] e_wn, input logic [31:0] e_bt);
        vec_t v;
        v.name = name; v.aluop = aluop; v.alusrc = alusrc; v.regdst = regdst; v.pc = pc;
        v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.rt = rt; v.rd = rd; v.shamt = shamt;
        v.wb = wb; v.mem = mem; v.e_bubble = e_bubble; v.e_res = e_res; v.e_zero = e_zero;
        v.e_wn = e_wn; v.e_bt = e_bt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ALUop = v.aluop; ALUsrc = v.alusrc; RegDst = v.regdst; pc_in = v.pc;
        RD1_in = v.rd1; RD2_in = v.rd2; immed_exted_in = v.imm; Rt_in = v.rt;
        Rd_in = v.rd; shamt_in = v.shamt; WB_ctl_in = v.wb; MEM_ctl_in = v.mem;
    endtask

    task automatic drive_r(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
        ALUop = 2'b10; ALUsrc = 1'b0; RegDst = 1'b1; pc_in = 32'h0000_0400;
        RD1_in = a; RD2_in = b; immed_exted_in = {26'd0, funct}; Rt_in = 5'd2;
        Rd_in = 5'd3; shamt_in = 5'd0; WB_ctl_in = 2'b11; MEM_ctl_in = 4'b1010;
    endtask

    task automatic drive_nop();
        ALUop = 2'b00; ALUsrc = 1'b0; RegDst = 1'b0; pc_in = 32'd0; RD1_in = 32'd0;
        RD2_in = 32'd0; immed_exted_in = 32'd0; Rt_in = 5'd0; Rd_in = 5'd0; shamt_in = 5'd0;
        WB_ctl_in = 2'b00; MEM_ctl_in = 4'b0000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string name);
        check({name, ".wb"},  32'(WB_ctl_out), 32'd0);
        check({name, ".mem"}, 32'(MEM_ctl_out), 32'd0);
        check({name, ".res"}, ALU_result_out, 32'd0);
    endtask

    // Issues a multiply, holds it while stalled, checks stall length and bubbles, retires it.
    task automatic do_mul(input string name, input logic [5:0] funct, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cycles);
        int cycles = 0;
        drive_r(funct, a, b);
        #1;
        while (stall_out === 1'b1 && cycles < 200) begin
            cycles++;
            step();
            check_bubble({name, ".busy"});
        end
        check({name, ".stall_cycles"}, 32'(cycles), 32'(exp_cycles));
        check({name, ".stall_low"}, 32'(stall_out), 32'd0);
        step();
        drive_nop();
        check_bubble({name, ".retire"});
    endtask

    task automatic check_hilo(input string name, input logic [31:0] e_hi, input logic [31:0] e_lo);
        drive_r(6'h10, 32'd0, 32'd0);
        step();
        check({name, ".mfhi"}, ALU_result_out, e_hi);
        drive_r(6'h12, 32'd0, 32'd0);
        step();
        check({name, ".mflo"}, ALU_result_out, e_lo);
        drive_nop();
    endtask

    initial begin
        vecs[0]  = mk("add_ovf", 2'b10, 1'b0, 1'b1, 32'h200, 32'h7FFF_FFFF, 32'h1, 32'h20, 5'd3, 5'd5, 5'd0,
                      2'b10, 4'b0000, 1'b0, 32'h8000_0000, 1'b0, 5'd5, 32'h280);
        vecs[1]  = mk("beq", 2'b01, 1'b0, 1'b0, 32'h100, 32'h1234, 32'h1234, 32'hFFFF_FFFE, 5'd7, 5'd9, 5'd0,
                      2'b00, 4'b0001, 1'b0, 32'h0, 1'b1, 5'd7, 32'hF8);
        vecs[2]  = mk("sub", 2'b10, 1'b0, 1'b1, 32'h0, 32'h5, 32'h7, 32'h22, 5'd1, 5'd9, 5'd0,
                      2'b10, 4'b0000, 1'b0, 32'hFFFF_FFFE, 1'b0, 5'd9, 32'h88);
        vecs[3]  = mk("and", 2'b10, 1'b0, 1'b1, 32'h1000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h24, 5'd1, 5'd10, 5'd0,
                      2'b10, 4'b0000, 1'b0, 32'hF000_F000, 1'b0, 5'd10, 32'h1090);
        vecs[4]  = mk("or", 2'b10, 1'b0, 1'b1, 32'h0, 32'h0000_FFFF, 32'h1234_0000, 32'h25, 5'd1, 5'd11, 5'd0,
                      2'b10, 4'b0000, 1'b0, 32'h1234_FFFF, 1'b0, 5'd11, 32'h94);
        vecs[5]  = mk("slt_true", 2'b10, 1'b0, 1'b1, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h2A, 5'd1, 5'd12, 5'd0,
                      2'b10, 4'b0000, 1'b0, 32'h1, 1'b0, 5'd12, 32'hA8);
        vecs[6]  = mk("slt_false", 2'b10, 1'b0, 1'b1, 32'h0, 32'h5, 32'hFFFF_FFFF, 32'h2A, 5'd1, 5'd13, 5'd0,
                      2'b10, 4'b0000, 1'b0, 32'h0, 1'b1, 5'd13, 32'hA8);
        vecs[7]  = mk("sll", 2'b10, 1'b0, 1'b1, 32'h40, 32'h0, 32'h8000_0001, 32'h0, 5'd1, 5'd14, 5'd4,
                      2'b10, 4'b0000, 1'b0, 32'h10, 1'b0, 5'd14, 32'h40);
        vecs[8]  = mk("srl", 2'b10, 1'b0, 1'b1, 32'h0, 32'h0, 32'h8000_0000, 32'h2, 5'd1, 5'd15, 5'd31,
                      2'b10, 4'b0000, 1'b0, 32'h1, 1'b0, 5'd15, 32'h8);
        vecs[9]  = mk("lw_addr", 2'b00, 1'b1, 1'b0, 32'h300, 32'h1000, 32'hDEAD, 32'hFFFF_FFFC, 5'd4, 5'd20, 5'd0,
                      2'b11, 4'b0100, 1'b0, 32'hFFC, 1'b0, 5'd4, 32'h2F0);
        vecs[10] = mk("ori", 2'b11, 1'b1, 1'b0, 32'h0, 32'h00F0, 32'h5, 32'h000F, 5'd6, 5'd21, 5'd0,
                      2'b10, 4'b0000, 1'b0, 32'hFF, 1'b0, 5'd6, 32'h3C);
        vecs[11] = mk("bad_funct", 2'b10, 1'b0, 1'b1, 32'h500, 32'h7, 32'h9, 32'h3F, 5'd1, 5'd22, 5'd0,
                      2'b11, 4'b1111, 1'b1, 32'h0, 1'b0, 5'd0, 32'h0);
        vecs[12] = mk("add_zero", 2'b00, 1'b0, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd8, 5'd23, 5'd0,
                      2'b10, 4'b0000, 1'b0, 32'h0, 1'b1, 5'd8, 32'h10);

        // Reset with nonzero inputs
        drive(vecs[0]);
        rst = 1'b1;
        step();
        step();
        check("rst.res", ALU_result_out, 32'd0);
        check("rst.wb", 32'(WB_ctl_out), 32'd0);
        check("rst.wn", 32'(WN_out), 32'd0);
        check("rst.bt", branch_target_out, 32'd0);
        check("rst.rd2", RD2_out, 32'd0);
        check("rst.stall", 32'(stall_out), 32'd0);
        rst = 1'b0;
        check_hilo("rst", 32'd0, 32'd0);

        foreach (vecs[k]) begin
            drive(vecs[k]);
            step();
            check({vecs[k].name, ".res"},  ALU_result_out, vecs[k].e_res);
            check({vecs[k].name, ".zero"}, 32'(zero_out), 32'(vecs[k].e_zero));
            check({vecs[k].name, ".wn"},   32'(WN_out), 32'(vecs[k].e_wn));
            check({vecs[k].name, ".bt"},   branch_target_out, vecs[k].e_bt);
            check({vecs[k].name, ".wb"},   32'(WB_ctl_out), vecs[k].e_bubble ? 32'd0 : 32'(vecs[k].wb));
            check({vecs[k].name, ".mem"},  32'(MEM_ctl_out), vecs[k].e_bubble ? 32'd0 : 32'(vecs[k].mem));
            check({vecs[k].name, ".rd2"},  RD2_out, vecs[k].e_bubble ? 32'd0 : vecs[k].rd2);
            check({vecs[k].name, ".stall"}, 32'(stall_out), 32'd0);
        end

        do_mul("multu1", 6'h19, 32'hFFFF_FFFF, 32'h2, 33);
        check_hilo("multu1", 32'h1, 32'hFFFF_FFFE);

        // Reset on BUSY cycle 10 aborts the multiply and clears HI/LO
        drive_r(6'h19, 32'h1234_5678, 32'h9ABC_DEF0);
        for (int c = 0; c < 10; c++) step();
        check("midrst.stall_before", 32'(stall_out), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive_nop();
        #1;
        check("midrst.stall", 32'(stall_out), 32'd0);
        check_bubble("midrst");
        check_hilo("midrst", 32'd0, 32'd0);

        do_mul("multu2", 6'h19, 32'h8000_0001, 32'h4, 33);
        check_hilo("multu2", 32'h2, 32'h4);

`ifdef MULT_SIGNED_EN
        do_mul("mult", 6'h18, 32'hFFFF_FFFD, 32'h5, 33);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
`else
        do_mul("mult", 6'h18, 32'hFFFF_FFFD, 32'h5, 0);
        check_hilo("mult", 32'h2, 32'h4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute stage plus EX/MEM pipeline register of the 5-stage MIPS pipeline.
- Consumes the ID/EX register outputs and performs ALU control decode, ALU operation, branch-target add and write-register select. Registers the results for the MEM stage.
- Adds a multi-cycle unsigned multiplier with HI/LO registers. Raises a stall to the hazard unit while the multiplier is busy.

Parameters:
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per BUSY cycle; legal values 1, 2, 4; BUSY lasts 32/MUL_BITS_PER_CYCLE cycles

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
WB_ctl_in  in  2  WB control from ID/EX
MEM_ctl_in  in  4  MEM control from ID/EX
ALUop  in  2  00 add, 01 sub, 10 R-type (funct decode), 11 or
ALUsrc  in  1  1: operand B = immed_exted_in; 0: RD2_in
RegDst  in  1  1: write reg = Rd_in; 0: Rt_in
pc_in  in  32  PC+4 of instruction
RD1_in  in  32  operand A
RD2_in  in  32  rt value
immed_exted_in  in  32  sign-extended immediate; [5:0] = funct
Rt_in  in  5  rt field
Rd_in  in  5  rd field
shamt_in  in  5  shift amount
WB_ctl_out  out  2  registered WB control
MEM_ctl_out  out  4  registered MEM control
branch_target_out  out  32  registered pc_in + (immed_exted_in << 2)
zero_out  out  1  registered (ALU result == 0)
ALU_result_out  out  32  registered ALU result
RD2_out  out  32  registered RD2_in (store data)
WN_out  out  5  registered write-register number
stall_out  out  1  combinational; hazard unit freezes PC, IF/ID and ID/EX while high

Behaviour:
- Reset: on a clk edge with rst=1, every registered output is 0, HI=LO=0 and the FSM goes to IDLE. Reset during BUSY aborts the multiply and leaves no HI/LO update.
- Latency: 1 cycle from inputs to EX/MEM outputs for all non-multiply instructions.
- ALUop=10 funct decode: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0/1), 0x00 sll RD2<<shamt, 0x02 srl RD2>>shamt (logical), 0x10 mfhi, 0x12 mflo, 0x19 multu. Any other funct is a bubble.
- Arithmetic: all 32-bit, wrap-around, no overflow trap.
- Branch target: 32-bit wrap-around add.
- Bubble: WB_ctl_out=0, MEM_ctl_out=0, other outputs 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, multu on inputs: stall_out=1; latch RD1/RD2 into multiplicand/multiplier; clear the 64-bit accumulator and the counter; go to BUSY; register a bubble.
  - BUSY: stall_out=1; each cycle retire MUL_BITS_PER_CYCLE multiplier bits (shift-add); register a bubble. After 32/MUL_BITS_PER_CYCLE cycles, write HI=product[63:32] and LO=product[31:0], then go to DONE.
  - DONE: stall_out=0; the held multu on the inputs is retired as a bubble and does not restart; go to IDLE.
- Total stall: 1 + 32/MUL_BITS_PER_CYCLE cycles.
- Inputs are ignored during BUSY. Operands are taken from the IDLE-cycle latch only.
- mfhi/mflo issued in the cycle after DONE read the new HI/LO values (HI/LO update at the DONE entry edge).

Optional Feature:
MULT_SIGNED_EN
- Defined: funct 0x18 (mult) is a signed 32x32 multiply, implemented as a magnitude multiply with the sign fixed up at the DONE entry edge. Timing and stall are identical to multu.
- Undefined: funct 0x18 is a bubble with no stall and no HI/LO change.

Test Plan:
- Reset: rst=1 for 2 cycles with nonzero inputs -> all outputs 0, stall_out=0. Then mfhi -> ALU_result_out=0.
- Add: ALUop=10, funct 0x20, RD1=0x7FFFFFFF, RD2=1, RegDst=1, Rd=5 -> next edge ALU_result_out=0x80000000, WN_out=5, zero_out=0.
- Branch: ALUop=01, RD1=RD2=0x1234, pc_in=0x100, imm=0xFFFFFFFE -> zero_out=1, branch_target_out=0xF8.
- Multiply: multu RD1=0xFFFFFFFF, RD2=2 with inputs held while stall_out=1 (MUL_BITS_PER_CYCLE=1) -> stall_out high exactly 33 cycles, bubbles throughout. Then mfhi returns 1 and mflo returns 0xFFFFFFFE.
- Reset mid-multiply: rst on BUSY cycle 10 -> FSM IDLE, stall_out=0, HI=LO=0.
- MULT_SIGNED_EN defined: mult -3 x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Undefined: same stimulus -> no stall, HI/LO unchanged.
